stopwatch_mode_ctrl: RTL
========================

Name: stopwatch_mode_ctrl

Overview:
- Produces the 2-bit stopwatch mode code consumed by the LED indicator and the time counter.
- Takes raw pushbuttons (start/stop, mode, clear) and the down-counter zero flag.
- Debounces and edge-detects each button, then runs the four-state mode FSM.
- Drives counter enable, direction, a clear strobe and a done strobe.

Parameters:
- DEBOUNCE_CYCLES, 20'd500000: consecutive stable samples needed to accept a button level change (minimum 2).
- ALARM_CYCLES, 24'd5000000: alarm output duration in clk cycles (used only with STOPWATCH_ALARM_EN).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous, active-low reset
- btn_start  input  1  raw start/stop button, active-high, asynchronous
- btn_mode  input  1  raw up/down mode button, active-high, asynchronous
- btn_clear  input  1  raw clear button, active-high, asynchronous
- count_zero  input  1  down counter is at 00:00, level
- current_state  output  2  00 up_wait, 01 up_run, 10 down_wait, 11 down_run (registered)
- count_en  output  1  equals current_state[0]
- count_dir  output  1  equals current_state[1]; 1 = count down
- clear_pulse  output  1  one-cycle counter clear strobe (registered)
- done_pulse  output  1  one-cycle strobe on down-count auto-stop (registered)
- alarm  output  1  alarm level (see Optional Feature)

Behaviour:
- Reset:
  - Synchronous, rst_n sampled low on a clk edge.
  - current_state=00, clear_pulse=0, done_pulse=0, alarm=0.
  - Synchronizers, debounced levels, debounce counters and alarm counter all 0.
  - Reset mid-run returns to up_wait on that edge; no clear_pulse is issued.
- Input conditioning, per button:
  - 2-flop synchronizer.
  - Debounce counter: resets to 0 whenever the synchronized sample equals the debounced level, otherwise increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a differing sample, the debounced level flips and the counter clears.
  - Event = registered rising edge of the debounced level, exactly one cycle wide.
  - Button release produces no event.
  - Glitches shorter than DEBOUNCE_CYCLES samples are ignored.
- Event latency: press held from edge N gives its event high in cycle N+DEBOUNCE_CYCLES+2. The FSM acts on the following edge.
- Event priority when several occur in one cycle: clear > start > mode. Lower-priority events in that cycle are dropped.
- count_zero is sampled directly; it is already synchronous to clk.
- FSM transitions (all other cases hold state):
  - up_wait:
    - clear_evt -> up_wait, clear_pulse=1
    - start_evt -> up_run
    - mode_evt -> down_wait, clear_pulse=1
  - up_run:
    - clear_evt -> up_wait, clear_pulse=1
    - start_evt -> up_wait
    - mode_evt ignored
  - down_wait:
    - clear_evt -> down_wait, clear_pulse=1
    - start_evt with count_zero=0 -> down_run
    - start_evt with count_zero=1 -> ignored, stays down_wait
    - mode_evt -> up_wait, clear_pulse=1
  - down_run:
    - clear_evt -> down_wait, clear_pulse=1
    - count_zero=1 -> down_wait, done_pulse=1. Takes precedence over start_evt and mode_evt in the same cycle.
    - start_evt -> down_wait
    - mode_evt ignored
- Strobe timing: clear_pulse and done_pulse are asserted in the same cycle the new state is visible and last exactly one cycle.
- Up-count overflow is the counter's concern; this block does not react to it.

Optional Feature:
- Macro STOPWATCH_ALARM_EN.
- Defined:
  - done_pulse loads the alarm counter and sets alarm=1 the following cycle.
  - alarm stays high for ALARM_CYCLES cycles, then drops.
  - Any button event (start, mode or clear) drops alarm on the next edge and clears the counter; the event is still processed normally by the FSM.
  - A new done_pulse while the alarm is active reloads the counter.
- Undefined: alarm is tied to 0 and no alarm counter is built.

Test Plan (DEBOUNCE_CYCLES=4, ALARM_CYCLES=8):
- Reset:
  - Stimulus: hold rst_n=0 for 3 cycles while in down_run.
  - Required: current_state=00, count_en=0, clear_pulse=0 after the first reset edge.
- Debounce:
  - Stimulus: btn_start high for 3 cycles, then low.
  - Required: no state change.
  - Stimulus: btn_start held high 10 cycles.
  - Required: current_state 00->01 exactly once; release causes no change.
- Mode cycle:
  - Stimulus: from up_wait press mode, then mode again.
  - Required: 00->10 with clear_pulse=1 for one cycle, then 10->00 with clear_pulse=1.
  - Stimulus: press mode in up_run.
  - Required: stays 01.
- Down run:
  - Stimulus: down_wait, count_zero=0, press start.
  - Required: 11, count_en=1, count_dir=1.
  - Stimulus: raise count_zero.
  - Required: next edge 10, done_pulse=1 for one cycle.
  - Stimulus: press start while count_zero=1.
  - Required: stays 10.
- Simultaneous:
  - Stimulus: start and clear events in the same cycle in up_run.
  - Required: 00 with clear_pulse=1.
  - Stimulus: count_zero=1 and start_evt together in down_run.
  - Required: 10 with done_pulse=1.
- Alarm (STOPWATCH_ALARM_EN):
  - Stimulus: trigger auto-stop.
  - Required: alarm high 8 cycles.
  - Stimulus: repeat, then press clear during the alarm.
  - Required: alarm low on the edge after clear_evt; without the macro, alarm is always 0.

Source files
------------

// File: rtl/stopwatch_mode_ctrl.sv
// Stopwatch mode controller: button conditioning plus the up/down run/wait FSM.
// Optional alarm output is built only when STOPWATCH_ALARM_EN is defined.
//
// state      | meaning
// up_wait    | counting up, paused
// up_run     | counting up
// down_wait  | counting down, paused
// down_run   | counting down until count_zero
module stopwatch_mode_ctrl #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter logic [23:0] ALARM_CYCLES    = 24'd5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_mode,
  input  logic       btn_clear,
  input  logic       count_zero,
  output logic [1:0] current_state,
  output logic       count_en,
  output logic       count_dir,
  output logic       clear_pulse,
  output logic       done_pulse,
  output logic       alarm
);

  typedef enum logic [1:0] {
    st_up_wait   = 2'b00,
    st_up_run    = 2'b01,
    st_down_wait = 2'b10,
    st_down_run  = 2'b11
  } state_t;

  // bit 0 start, bit 1 mode, bit 2 clear
  logic [2:0]  btn_raw;
  logic [2:0]  sync1, sync2;
  logic [2:0]  deb, deb_q;
  logic [2:0]  evt;
  logic [19:0] deb_cnt [3];

  assign btn_raw = {btn_clear, btn_mode, btn_start};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      evt   <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      deb_q <= deb;
      evt   <= deb & ~deb_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEBOUNCE_CYCLES - 20'd1) begin
          deb[i]     <= ~deb[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 20'd1;
        end
      end
    end
  end

  logic start_evt, mode_evt, clear_evt;
  assign start_evt = evt[0];
  assign mode_evt  = evt[1];
  assign clear_evt = evt[2];

  state_t state, state_nxt;
  logic   clear_nxt, done_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= st_up_wait;
      clear_pulse <= 1'b0;
      done_pulse  <= 1'b0;
    end else begin
      state       <= state_nxt;
      clear_pulse <= clear_nxt;
      done_pulse  <= done_nxt;
    end
  end

  // priority clear > start > mode; in down_run count_zero sits just below clear
  always_comb begin
    state_nxt = state;
    clear_nxt = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      st_up_wait: begin
        if (clear_evt) begin
          clear_nxt = 1'b1;
        end else if (start_evt) begin
          state_nxt = st_up_run;
        end else if (mode_evt) begin
          state_nxt = st_down_wait;
          clear_nxt = 1'b1;
        end
      end
      st_up_run: begin
        if (clear_evt) begin
          state_nxt = st_up_wait;
          clear_nxt = 1'b1;
        end else if (start_evt) begin
          state_nxt = st_up_wait;
        end
      end
      st_down_wait: begin
        if (clear_evt) begin
          clear_nxt = 1'b1;
        end else if (start_evt) begin
          if (!count_zero) state_nxt = st_down_run;
        end else if (mode_evt) begin
          state_nxt = st_up_wait;
          clear_nxt = 1'b1;
        end
      end
      st_down_run: begin
        if (clear_evt) begin
          state_nxt = st_down_wait;
          clear_nxt = 1'b1;
        end else if (count_zero) begin
          state_nxt = st_down_wait;
          done_nxt  = 1'b1;
        end else if (start_evt) begin
          state_nxt = st_down_wait;
        end
      end
      default: state_nxt = st_up_wait;
    endcase
  end

  assign current_state = state;
  assign count_en      = state[0];
  assign count_dir     = state[1];

`ifdef STOPWATCH_ALARM_EN
  logic [23:0] alarm_cnt;
  logic        alarm_q;

  // a fresh auto-stop reloads the alarm even if a button event lands the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alarm_q   <= 1'b0;
      alarm_cnt <= '0;
    end else if (done_pulse) begin
      alarm_q   <= 1'b1;
      alarm_cnt <= ALARM_CYCLES - 24'd1;
    end else if (|evt) begin
      alarm_q   <= 1'b0;
      alarm_cnt <= '0;
    end else if (alarm_q) begin
      if (alarm_cnt == 24'd0) alarm_q <= 1'b0;
      else                    alarm_cnt <= alarm_cnt - 24'd1;
    end
  end

  assign alarm = alarm_q;
`else
  // no alarm hardware; the parameter only appears so the port list stays uniform
  assign alarm = 1'b0 & (ALARM_CYCLES != 24'd0);
`endif

endmodule
